// File: rtl/ws2812_frame_sequencer_if.sv
// Pixel/latch handshake between the frame sequencer and the ws2812 bit driver.
// The sequencer is the master; the bit driver answers with ready.
interface ws2812_frame_sequencer_if;
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;
  logic       load;
  logic       reset;
  logic       ready;

  modport master (
    output r, g, b, load, reset,
    input  ready
  );

  modport slave (
    input  r, g, b, load, reset,
    output ready
  );
endinterface

// File: rtl/ws2812_frame_sequencer.sv
// Pixel buffer plus frame FSM feeding the ws2812 bit driver:
// one load per pixel in index order, then a single latch strobe.
module ws2812_frame_sequencer #(
  parameter int NUM_LEDS = 10,
  parameter int IDX_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en_i,
  input  logic [IDX_W-1:0]          wr_addr_i,
  input  logic [23:0]               wr_rgb_i,
  input  logic                      frame_start_i,
  output logic                      busy_o,
  output logic                      frame_done_o,
  ws2812_frame_sequencer_if.master  drv
);

  localparam int AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_LEDS - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] ACK   = 3'd2;
  localparam logic [2:0] XFER  = 3'd3;
  localparam logic [2:0] LATCH = 3'd4;
  localparam logic [2:0] LACK  = 3'd5;
  localparam logic [2:0] LWAIT = 3'd6;

  logic [23:0]      buf_q [NUM_LEDS];
  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load_q, load_d;
  logic             rst_q, rst_d;
  logic [7:0]       r_q, r_d;
  logic [7:0]       g_q, g_d;
  logic [7:0]       b_q, b_d;

  // Out-of-range addresses are dropped, never aliased onto a valid pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LEDS; i++)
        buf_q[i] <= '0;
    end else if (wr_en_i && (wr_addr_i <= LAST)) begin
      buf_q[wr_addr_i[AW-1:0]] <= wr_rgb_i;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load_d  = 1'b0;
    rst_d   = 1'b0;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    case (state_q)
      IDLE: begin
        if (frame_start_i) begin
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (drv.ready) begin
          {r_d, g_d, b_d} = buf_q[idx_q[AW-1:0]];
          load_d  = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!drv.ready)
          state_d = XFER;
      end
      XFER: begin
        if (drv.ready) begin
          if (idx_q == LAST) begin
            state_d = LATCH;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ISSUE;
          end
        end
      end
      LATCH: begin
        if (drv.ready) begin
          rst_d   = 1'b1;
          state_d = LACK;
        end
      end
      LACK: begin
        if (!drv.ready)
          state_d = LWAIT;
      end
      LWAIT: begin
        if (drv.ready) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      load_q  <= 1'b0;
      rst_q   <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      load_q  <= load_d;
      rst_q   <= rst_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
    end
  end

  assign busy_o       = busy_q;
  assign frame_done_o = done_q;
  assign drv.load     = load_q;
  assign drv.reset    = rst_q;
  assign drv.r        = r_q;
  assign drv.g        = g_q;
  assign drv.b        = b_q;

endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// Directed bench for ws2812_frame_sequencer with a 3-pixel strip
// and a simple bit-driver model answering the load/reset handshake.
module tb_ws2812_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_addr = '0;
  logic [23:0] wr_rgb = '0;
  logic        frame_start = 1'b0;
  logic        busy;
  logic        frame_done;

  ws2812_frame_sequencer_if drv_if ();

  ws2812_frame_sequencer #(
    .NUM_LEDS (3),
    .IDX_W    (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en_i       (wr_en),
    .wr_addr_i     (wr_addr),
    .wr_rgb_i      (wr_rgb),
    .frame_start_i (frame_start),
    .busy_o        (busy),
    .frame_done_o  (frame_done),
    .drv           (drv_if.master)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad = 0;

  int          load_cnt = 0;
  int          rst_cnt = 0;
  int          done_cnt = 0;
  int          overlap = 0;
  int          loads_at_rst = 0;
  int          cnt = 0;
  logic        hold = 1'b0;
  logic [23:0] cap [16];

  initial drv_if.ready = 1'b1;

  // Driver model: drops ready after each strobe, stays busy 4 cycles.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      cnt = 0;
    end else begin
      if (drv_if.load && drv_if.reset) overlap++;
      if (drv_if.load) begin
        if (load_cnt < 16) cap[load_cnt] = {drv_if.r, drv_if.g, drv_if.b};
        load_cnt++;
        cnt = 4;
      end else if (drv_if.reset) begin
        loads_at_rst = load_cnt;
        rst_cnt++;
        cnt = 4;
      end else if (cnt > 0) begin
        cnt--;
      end
      if (frame_done) done_cnt++;
    end
    drv_if.ready = (cnt == 0) && !hold;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [23:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_rgb = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic clr();
    load_cnt = 0; rst_cnt = 0; done_cnt = 0; loads_at_rst = 0;
    for (int i = 0; i < 16; i++) cap[i] = 24'hxxxxxx;
  endtask

  task automatic start();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_cnt == 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", (done_cnt == 0) ? 1 : 0, 0);
  endtask

  task automatic chk_frame(input string tag, input logic [23:0] p0,
                           input logic [23:0] p1, input logic [23:0] p2);
    chk({tag, "_loads"}, load_cnt, 3);
    chk({tag, "_p0"}, cap[0], p0);
    chk({tag, "_p1"}, cap[1], p1);
    chk({tag, "_p2"}, cap[2], p2);
    chk({tag, "_rsts"}, rst_cnt, 1);
    chk({tag, "_rst_after"}, loads_at_rst, 3);
    chk({tag, "_dones"}, done_cnt, 1);
  endtask

  initial begin
    int n;
    clr();
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_load", drv_if.load, 0);
    chk("rst_reset", drv_if.reset, 0);
    chk("rst_rgb", {drv_if.r, drv_if.g, drv_if.b}, 0);
    rst_n = 1'b1;

    // basic frame
    wr(8'd0, 24'hFF0000);
    wr(8'd1, 24'h00FF00);
    wr(8'd2, 24'h0000FF);
    clr();
    start();
    chk("t1_busy", busy, 1);
    wait_done();
    chk_frame("t1", 24'hFF0000, 24'h00FF00, 24'h0000FF);
    @(negedge clk);
    chk("t1_idle", busy, 0);

    // stalled driver, release, plus ignored frame_start while busy
    clr();
    @(negedge clk);
    hold = 1'b1; drv_if.ready = 1'b0;
    start();
    repeat (100) @(negedge clk);
    chk("t2_noload", load_cnt, 0);
    chk("t2_busy", busy, 1);
    hold = 1'b0; drv_if.ready = 1'b1;
    @(negedge clk);
    chk("t2_load_hi", drv_if.load, 1);
    @(negedge clk);
    chk("t2_load_lo", drv_if.load, 0);
    start();
    wait_done();
    chk_frame("t3", 24'hFF0000, 24'h00FF00, 24'h0000FF);
    repeat (30) @(negedge clk);
    chk("t3_noqueue", load_cnt, 3);
    chk("t3_onedone", done_cnt, 1);

    // out-of-range writes dropped, in-flight write to pixel 2 visible
    wr(8'd7, 24'hDEAD01);
    wr(8'd4, 24'hDEAD02);
    wr(8'd5, 24'hDEAD03);
    clr();
    start();
    n = 0;
    while (load_cnt < 1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t4_first_load", load_cnt, 1);
    wr(8'd2, 24'h123456);
    wait_done();
    chk_frame("t4", 24'hFF0000, 24'h00FF00, 24'h123456);

    // back-to-back frame, frame_start right after frame_done
    clr();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    wait_done();
    chk_frame("t6", 24'hFF0000, 24'h00FF00, 24'h123456);

    // asynchronous reset during the second load
    clr();
    start();
    n = 0;
    while (!(drv_if.load && load_cnt == 2) && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("t5_in_load2", drv_if.load, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_load", drv_if.load, 0);
    chk("t5_reset", drv_if.reset, 0);
    chk("t5_done", frame_done, 0);
    chk("t5_rgb", {drv_if.r, drv_if.g, drv_if.b}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    clr();
    start();
    wait_done();
    chk_frame("t5", 24'h0, 24'h0, 24'h0);

    chk("no_overlap", overlap, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
